// File: rtl/src_dp_pkg.sv
// Shared constants and enums for the Mini-SRC single-bus datapath.
package src_dp_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    SRC_PC  = 3'd0,
    SRC_ZLO = 3'd1,
    SRC_ZHI = 3'd2,
    SRC_MDR = 3'd3,
    SRC_R2  = 3'd4,
    SRC_R3  = 3'd5
  } bus_src_e;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_ADD  = 2'd1,
    OP_MUL  = 2'd2
  } alu_op_e;

  // Slot numbers in the datapath register bank
  localparam int RG_PC  = 0;
  localparam int RG_IR  = 1;
  localparam int RG_MAR = 2;
  localparam int RG_MDR = 3;
  localparam int RG_R1  = 4;
  localparam int RG_R2  = 5;
  localparam int RG_R3  = 6;
  localparam int RG_Y   = 7;
  localparam int RG_HI  = 8;
  localparam int RG_LO  = 9;
  localparam int RG_ZHI = 10;
  localparam int RG_ZLO = 11;
  localparam int NREG   = 12;
endpackage

// File: rtl/dp_reg32.sv
// Datapath register: load enable, synchronous clear that beats the load.
import src_dp_pkg::*;

module dp_reg32 #(
  parameter int W = DATA_W
) (
  input  logic         Clock,
  input  logic         clear,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge Clock) begin
    if (clear)   q <= '0;
    else if (ld) q <= d;
  end
endmodule

// File: rtl/src_datapath.sv
// Mini-SRC 32-bit single-bus datapath: register bank, priority bus mux, ADD/MUL ALU.
import src_dp_pkg::*;

module src_datapath (
  input  logic              Clock,
  input  logic              clear,
  input  logic              PCout,
  input  logic              Zlowout,
  input  logic              Zhighout,
  input  logic              MDRout,
  input  logic              R2out,
  input  logic              R3out,
  input  logic              MARin,
  input  logic              Zin,
  input  logic              PCin,
  input  logic              MDRin,
  input  logic              IRin,
  input  logic              Yin,
  input  logic              LOin,
  input  logic              HIin,
  input  logic              R1in,
  input  logic              R2in,
  input  logic              R3in,
  input  logic              IncPC,
  input  logic              Read,
  input  logic              ADD,
  input  logic              MUL,
  input  logic [DATA_W-1:0] Mdatain,
  output logic [DATA_W-1:0] BusMuxOut,
  output logic [DATA_W-1:0] PC_q,
  output logic [DATA_W-1:0] IR_q,
  output logic [DATA_W-1:0] MAR_q,
  output logic [DATA_W-1:0] R1_q,
  output logic [DATA_W-1:0] R2_q,
  output logic [DATA_W-1:0] R3_q,
  output logic [DATA_W-1:0] HI_q,
  output logic [DATA_W-1:0] LO_q,
  output logic [DATA_W-1:0] Zhigh_q,
  output logic [DATA_W-1:0] Zlow_q
);
  logic [NREG-1:0]             reg_ld;
  logic [NREG-1:0][DATA_W-1:0] reg_d;
  logic [NREG-1:0][DATA_W-1:0] reg_q;

  bus_src_e              bus_sel;
  logic                  bus_vld;
  alu_op_e               alu_op;
  logic [2*DATA_W-1:0]   alu_res;
  logic [2*DATA_W-1:0]   a_sx, b_sx;

  // Fixed-priority source select; no strobe leaves the bus at zero
  always_comb begin
    bus_vld = 1'b1;
    bus_sel = SRC_PC;
    if      (PCout)    bus_sel = SRC_PC;
    else if (Zlowout)  bus_sel = SRC_ZLO;
    else if (Zhighout) bus_sel = SRC_ZHI;
    else if (MDRout)   bus_sel = SRC_MDR;
    else if (R2out)    bus_sel = SRC_R2;
    else if (R3out)    bus_sel = SRC_R3;
    else               bus_vld = 1'b0;

    BusMuxOut = '0;
    if (bus_vld) begin
      case (bus_sel)
        SRC_PC:  BusMuxOut = reg_q[RG_PC];
        SRC_ZLO: BusMuxOut = reg_q[RG_ZLO];
        SRC_ZHI: BusMuxOut = reg_q[RG_ZHI];
        SRC_MDR: BusMuxOut = reg_q[RG_MDR];
        SRC_R2:  BusMuxOut = reg_q[RG_R2];
        SRC_R3:  BusMuxOut = reg_q[RG_R3];
        default: BusMuxOut = '0;
      endcase
    end
  end

  // Signed product via explicit sign extension; low 2*DATA_W bits are exact
  assign a_sx = {{DATA_W{reg_q[RG_Y][DATA_W-1]}}, reg_q[RG_Y]};
  assign b_sx = {{DATA_W{BusMuxOut[DATA_W-1]}}, BusMuxOut};

  always_comb begin
    alu_op = MUL ? OP_MUL : (ADD ? OP_ADD : OP_PASS);
    case (alu_op)
      OP_MUL:  alu_res = a_sx * b_sx;
      OP_ADD:  alu_res = {{DATA_W{1'b0}}, reg_q[RG_Y] + BusMuxOut};
      default: alu_res = {{DATA_W{1'b0}}, BusMuxOut};
    endcase
  end

  always_comb begin
    reg_ld = '0;
    reg_d  = '0;
    for (int i = 0; i < NREG; i++) reg_d[i] = BusMuxOut;
    reg_ld[RG_PC]  = IncPC | PCin;
    reg_d[RG_PC]   = IncPC ? reg_q[RG_PC] + 1'b1 : BusMuxOut;
    reg_ld[RG_IR]  = IRin;
    reg_ld[RG_MAR] = MARin;
    reg_ld[RG_MDR] = MDRin;
    reg_d[RG_MDR]  = Read ? Mdatain : BusMuxOut;
    reg_ld[RG_R1]  = R1in;
    reg_ld[RG_R2]  = R2in;
    reg_ld[RG_R3]  = R3in;
    reg_ld[RG_Y]   = Yin;
    reg_ld[RG_HI]  = HIin;
    reg_ld[RG_LO]  = LOin;
    reg_ld[RG_ZHI] = Zin;
    reg_d[RG_ZHI]  = alu_res[2*DATA_W-1:DATA_W];
    reg_ld[RG_ZLO] = Zin;
    reg_d[RG_ZLO]  = alu_res[DATA_W-1:0];
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    dp_reg32 #(.W(DATA_W)) u_reg (
      .Clock (Clock),
      .clear (clear),
      .ld    (reg_ld[g]),
      .d     (reg_d[g]),
      .q     (reg_q[g])
    );
  end

  assign PC_q    = reg_q[RG_PC];
  assign IR_q    = reg_q[RG_IR];
  assign MAR_q   = reg_q[RG_MAR];
  assign R1_q    = reg_q[RG_R1];
  assign R2_q    = reg_q[RG_R2];
  assign R3_q    = reg_q[RG_R3];
  assign HI_q    = reg_q[RG_HI];
  assign LO_q    = reg_q[RG_LO];
  assign Zhigh_q = reg_q[RG_ZHI];
  assign Zlow_q  = reg_q[RG_ZLO];
endmodule

// File: tb/tb_src_datapath.sv
// Directed-vector bench for src_datapath with hand-computed expectations.
module tb_src_datapath;
  logic        Clock = 1'b0;
  logic        clear;
  logic        PCout, Zlowout, Zhighout, MDRout, R2out, R3out;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, R1in, R2in, R3in;
  logic        IncPC, Read, ADD, MUL;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, PC_q, IR_q, MAR_q, R1_q, R2_q, R3_q, HI_q, LO_q, Zhigh_q, Zlow_q;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  src_datapath dut (
    .Clock(Clock), .clear(clear),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .R2out(R2out), .R3out(R3out),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .LOin(LOin), .HIin(HIin), .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .IncPC(IncPC), .Read(Read), .ADD(ADD), .MUL(MUL), .Mdatain(Mdatain),
    .BusMuxOut(BusMuxOut), .PC_q(PC_q), .IR_q(IR_q), .MAR_q(MAR_q),
    .R1_q(R1_q), .R2_q(R2_q), .R3_q(R3_q), .HI_q(HI_q), .LO_q(LO_q),
    .Zhigh_q(Zhigh_q), .Zlow_q(Zlow_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    clear = 0;
    {PCout, Zlowout, Zhighout, MDRout, R2out, R3out} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, R1in, R2in, R3in} = '0;
    {IncPC, Read, ADD, MUL} = '0;
  endtask

  // One clock: strobes set by caller act on this edge, then are dropped
  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic mem_to_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1; tick();
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_pc"}, PC_q, 0);   chk({pfx, "_ir"}, IR_q, 0);
    chk({pfx, "_mar"}, MAR_q, 0); chk({pfx, "_r1"}, R1_q, 0);
    chk({pfx, "_r2"}, R2_q, 0);   chk({pfx, "_r3"}, R3_q, 0);
    chk({pfx, "_hi"}, HI_q, 0);   chk({pfx, "_lo"}, LO_q, 0);
    chk({pfx, "_zhi"}, Zhigh_q, 0); chk({pfx, "_zlo"}, Zlow_q, 0);
  endtask

  initial begin
    idle();
    Mdatain = 0;
    @(negedge Clock);
    clear = 1; tick();
    chk_all_zero("rst");

    // Load R2 and R3 through MDR
    mem_to_mdr(32'h22);
    MDRout = 1; R2in = 1; #1;
    chk("bus_mdr", BusMuxOut, 32'h22);
    tick();
    chk("r2_load", R2_q, 32'h22);
    mem_to_mdr(32'h24);
    MDRout = 1; R3in = 1; tick();
    chk("r3_load", R3_q, 32'h24);

    // R1 = R2 + R3
    R2out = 1; Yin = 1; tick();
    R3out = 1; ADD = 1; Zin = 1; tick();
    chk("add_zlo", Zlow_q, 32'h46);
    chk("add_zhi", Zhigh_q, 0);
    Zlowout = 1; R1in = 1; tick();
    chk("r1_add", R1_q, 32'h46);

    // Instruction fetch
    PCout = 1; MARin = 1; tick();
    chk("mar_pc", MAR_q, 0);
    IncPC = 1; Mdatain = 32'h0091_8000; Read = 1; MDRin = 1; tick();
    chk("pc_inc", PC_q, 1);
    MDRout = 1; IRin = 1; tick();
    chk("ir_load", IR_q, 32'h0091_8000);

    // Signed multiply -2 * 3
    mem_to_mdr(32'hFFFF_FFFE);
    MDRout = 1; Yin = 1; tick();
    mem_to_mdr(32'h3);
    MDRout = 1; Zin = 1; tick();
    chk("pass_zlo", Zlow_q, 32'h3);
    chk("pass_zhi", Zhigh_q, 0);
    MDRout = 1; MUL = 1; ADD = 1; Zin = 1; tick();
    chk("mul_zhi", Zhigh_q, 32'hFFFF_FFFF);
    chk("mul_zlo", Zlow_q, 32'hFFFF_FFFA);
    Zhighout = 1; HIin = 1; tick();
    Zlowout = 1; LOin = 1; tick();
    chk("hi", HI_q, 32'hFFFF_FFFF);
    chk("lo", LO_q, 32'hFFFF_FFFA);

    // PC wrap, and IncPC beating PCin
    mem_to_mdr(32'hFFFF_FFFF);
    MDRout = 1; PCin = 1; tick();
    chk("pc_load", PC_q, 32'hFFFF_FFFF);
    IncPC = 1; tick();
    chk("pc_wrap", PC_q, 0);
    MDRout = 1; PCin = 1; IncPC = 1; tick();
    chk("pc_inc_ovr", PC_q, 1);

    // Add carry-out is discarded
    MDRout = 1; Yin = 1; tick();
    PCout = 1; ADD = 1; Zin = 1; tick();
    chk("add_wrap_zlo", Zlow_q, 0);
    chk("add_wrap_zhi", Zhigh_q, 0);

    // Bus priority and idle bus
    #1; chk("bus_idle", BusMuxOut, 0);
    PCout = 1; R2out = 1; #1;
    chk("bus_pc_r2", BusMuxOut, 32'h1);
    idle();
    MDRout = 1; Zhighout = 1; #1;
    chk("bus_zhi_mdr", BusMuxOut, 0);
    idle();
    R2out = 1; R3out = 1; #1;
    chk("bus_r2_r3", BusMuxOut, 32'h22);
    idle();

    // Z feeds back through the bus while Z is being written
    Zlowout = 1; ADD = 1; Zin = 1; #1;
    chk("bus_old_z", BusMuxOut, 0);
    tick();
    chk("z_new", Zlow_q, 32'hFFFF_FFFF);

    // Clear beats a pending load
    PCout = 1; R1in = 1; clear = 1; #1;
    chk("bus_pre_clr", BusMuxOut, 32'h1);
    tick();
    chk_all_zero("clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/src_datapath.md
Name: src_datapath

Overview:
- 32-bit single-bus datapath for the Mini-SRC processor.
- Contains PC, IR, MAR, MDR, general registers R1–R3, Y, 64-bit Z (Zhigh/Zlow), HI and LO, a bus multiplexer and an ADD/MUL ALU.
- Driven cycle-by-cycle by external one-hot control strobes (control unit or bench); memory data arrives on Mdatain.

Parameters:
- DATA_W, 32, width of bus and all single registers (Z is 2*DATA_W).

Ports:
- Clock  in  1  system clock; all registers update on rising edge.
- clear  in  1  synchronous active-high reset.
- PCout, Zlowout, Zhighout, MDRout, R2out, R3out  in  1 each  bus source selects.
- MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, R1in, R2in, R3in  in  1 each  register load enables.
- IncPC  in  1  increment PC.
- Read  in  1  MDR input mux select (1 = Mdatain, 0 = bus).
- ADD  in  1  ALU add.
- MUL  in  1  ALU signed multiply.
- Mdatain  in  32  memory read data.
- BusMuxOut  out  32  current bus value.
- PC_q, IR_q, MAR_q, R1_q, R2_q, R3_q, HI_q, LO_q, Zhigh_q, Zlow_q  out  32 each  register observation.

Behaviour:
- Bus (combinational):
  - Selected from PC, Zlow, Zhigh, MDR, R2, R3 by the *out strobes.
  - Priority when several are high: PCout > Zlowout > Zhighout > MDRout > R2out > R3out.
  - No strobe high: bus = 0.
- ALU (combinational):
  - A = Y, B = bus.
  - MUL: {Zhigh,Zlow} = signed 64-bit A*B.
  - Else ADD: Zlow = A+B modulo 2^32, Zhigh = 0.
  - Else (no op): Zlow = B, Zhigh = 0.
  - MUL has priority over ADD.
- Register loads on rising Clock:
  - Each register with its *in enable loads the bus.
  - Zin loads both Z halves from the ALU result.
  - MDRin loads Mdatain if Read=1, else the bus.
  - No enable: register holds its value.
- PC:
  - IncPC=1 → PC <= PC+1 (wraps 0xFFFFFFFF→0); this overrides PCin.
  - Else PCin=1 → PC <= bus.
- Reset: clear=1 at a rising edge zeroes every register (PC, IR, MAR, MDR, R1–R3, Y, Zhigh, Zlow, HI, LO); clear overrides all enables.
- Latency: a value driven onto the bus in cycle n is visible in its destination register's _q output after edge n; no handshakes.
- Simultaneous read/write of the same register in one cycle: the bus carries the old value; the register takes the new value at the edge.

Decomposition:
- Shared package src_dp_pkg:
  - DATA_W constant.
  - Bus-source index enum (PC, ZLO, ZHI, MDR, R2, R3).
  - ALU op enum (PASS, ADD, MUL).
- Natural sub-module: dp_reg32, a DATA_W register with load enable and synchronous clear, instantiated for each register.
- The ALU and bus mux stay inline.

Test Plan:
- Load sequence: Mdatain=0x22, Read=MDRin=1 for one edge; then MDRout=R2in=1 → R2_q=0x22. Repeat with 0x24 into R3 → R3_q=0x24.
- Add: R2out+Yin; then R3out+ADD+Zin; then Zlowout+R1in → R1_q=0x46, Zhigh_q=0.
- Fetch: PC=0; PCout+MARin → MAR_q=0. IncPC with Read+MDRin and Mdatain=0x00918000 → PC_q=1, MDR=0x00918000. MDRout+IRin → IR_q=0x00918000.
- Multiply: Y=0xFFFFFFFE (-2), bus=3, MUL+Zin → Zhigh_q=0xFFFFFFFF, Zlow_q=0xFFFFFFFA. Zhighout+HIin and Zlowout+LOin → HI/LO match.
- Boundaries:
  - PC=0xFFFFFFFF with IncPC → PC=0.
  - Y=0xFFFFFFFF, bus=1 with ADD → Zlow=0, Zhigh=0.
  - No bus strobe → BusMuxOut=0.
  - PCout and R2out together → bus=PC.
- Reset mid-operation: clear=1 together with R1in=1 and a non-zero bus → every _q output is 0 after the edge.
